// File: rtl/core_pkg.sv
// Shared core definitions: RV32I load/store funct3 codes, LSU state encoding
// and the byte-swap helper for the big-endian BRAM lane order.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        LOAD_WAIT,
        RESP
    } lsu_state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle of the load/store unit.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: fault detection, store lane placement/byte enables
// and load extraction/extension for the big-endian BRAM lane order.
module lsu_align
    import core_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] dout,
    output logic        fault,
    output logic [3:0]  we,
    output logic [31:0] din,
    output logic [31:0] rdata
);

    logic [31:0] load_le;

    // Byte offset o lives in lane 3-o, so shifting the little-endian value up
    // by o bytes and swapping lands each byte in its lane.
    assign din     = bswap32(wdata << {offset, 3'b000});
    assign load_le = bswap32(dout) >> {offset, 3'b000};

    always_comb begin
        fault = 1'b0;
        we    = '0;
        case (funct3)
            F3_B: we = 4'b1000 >> offset;
            F3_H: begin
                fault = offset[0];
                we    = 4'b1100 >> offset;
            end
            F3_W: begin
                fault = (offset != 2'b00);
                we    = 4'b1111;
            end
            F3_BU:   fault = store;
            F3_HU:   fault = store | offset[0];
            default: fault = 1'b1;
        endcase
        if (fault || !store) begin
            we = '0;
        end
    end

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{load_le[7]}}, load_le[7:0]};
            F3_H:    rdata = {{16{load_le[15]}}, load_le[15:0]};
            F3_W:    rdata = load_le;
            F3_BU:   rdata = {24'h0, load_le[7:0]};
            F3_HU:   rdata = {16'h0, load_le[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store per transaction against a BRAM
// port with configurable read latency, single-cycle response pulse to the core.
module load_store_unit
    import core_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      core,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic [3:0]            mem_we,
    input  logic [31:0]           mem_dout
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    lsu_state_e       state;
    logic [2:0]       funct3_q;
    logic [1:0]       offset_q;
    logic [CNT_W-1:0] cnt;

    logic             idle;
    logic [2:0]       al_funct3;
    logic [1:0]       al_offset;
    logic             al_fault;
    logic [3:0]       al_we;
    logic [31:0]      al_din;
    logic [31:0]      al_rdata;
    logic             unused_addr_hi;

    assign idle           = (state == IDLE);
    assign core.req_ready = idle && !rst;
    assign unused_addr_hi = ^core.req_addr[31:ADDR_WIDTH+2];

    // Request fields feed the aligner directly while idle, registered copies after.
    assign al_funct3 = idle ? core.req_funct3   : funct3_q;
    assign al_offset = idle ? core.req_addr[1:0] : offset_q;

    lsu_align u_align (
        .store  (core.req_store),
        .funct3 (al_funct3),
        .offset (al_offset),
        .wdata  (core.req_wdata),
        .dout   (mem_dout),
        .fault  (al_fault),
        .we     (al_we),
        .din    (al_din),
        .rdata  (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            funct3_q        <= '0;
            offset_q        <= '0;
            cnt             <= '0;
            mem_addr        <= '0;
            mem_din         <= '0;
            mem_we          <= '0;
            core.resp_valid <= 1'b0;
            core.resp_rdata <= '0;
            core.resp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (core.req_valid) begin
                        funct3_q <= core.req_funct3;
                        offset_q <= core.req_addr[1:0];
                        if (al_fault) begin
                            state           <= RESP;
                            core.resp_valid <= 1'b1;
                            core.resp_fault <= 1'b1;
                            core.resp_rdata <= '0;
                        end else begin
                            mem_addr <= core.req_addr[ADDR_WIDTH+1:2];
                            cnt      <= '0;
                            if (core.req_store) begin
                                state   <= STORE;
                                mem_we  <= al_we;
                                mem_din <= al_din;
                            end else begin
                                state <= LOAD_WAIT;
                            end
                        end
                    end
                end
                STORE: begin
                    mem_we          <= '0;
                    state           <= RESP;
                    core.resp_valid <= 1'b1;
                    core.resp_fault <= 1'b0;
                    core.resp_rdata <= '0;
                end
                LOAD_WAIT: begin
                    // One cycle of address setup plus MEM_LATENCY cycles of read.
                    if (cnt == CNT_W'(MEM_LATENCY)) begin
                        state           <= RESP;
                        core.resp_valid <= 1'b1;
                        core.resp_fault <= 1'b0;
                        core.resp_rdata <= al_rdata;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state           <= IDLE;
                    core.resp_valid <= 1'b0;
                    core.resp_fault <= 1'b0;
                    core.resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 3) with BRAM
// models, a byte-level reference model checked every cycle, and literal vectors.
module tb_load_store_unit;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rv[2], rs[2];
    logic [2:0]  rf[2];
    logic [31:0] ra[2], rw[2];
    logic        rdy[2], resp_v[2], resp_f[2];
    logic [31:0] resp_d[2];
    logic [14:0] maddr[2];
    logic [31:0] mdin[2];
    logic [3:0]  mwe[2];
    logic [31:0] mdout[2];

    load_store_unit_if if0 ();
    load_store_unit_if if1 ();

    assign if0.req_valid = rv[0];
    assign if0.req_store = rs[0];
    assign if0.req_funct3 = rf[0];
    assign if0.req_addr = ra[0];
    assign if0.req_wdata = rw[0];
    assign if1.req_valid = rv[1];
    assign if1.req_store = rs[1];
    assign if1.req_funct3 = rf[1];
    assign if1.req_addr = ra[1];
    assign if1.req_wdata = rw[1];
    assign rdy[0] = if0.req_ready;
    assign rdy[1] = if1.req_ready;
    assign resp_v[0] = if0.resp_valid;
    assign resp_v[1] = if1.resp_valid;
    assign resp_f[0] = if0.resp_fault;
    assign resp_f[1] = if1.resp_fault;
    assign resp_d[0] = if0.resp_rdata;
    assign resp_d[1] = if1.resp_rdata;

    load_store_unit #(.ADDR_WIDTH(15), .MEM_LATENCY(1)) u_lsu_l1 (
        .clk(clk), .rst(rst), .core(if0),
        .mem_addr(maddr[0]), .mem_din(mdin[0]), .mem_we(mwe[0]), .mem_dout(mdout[0])
    );

    load_store_unit #(.ADDR_WIDTH(15), .MEM_LATENCY(3)) u_lsu_l3 (
        .clk(clk), .rst(rst), .core(if1),
        .mem_addr(maddr[1]), .mem_din(mdin[1]), .mem_we(mwe[1]), .mem_dout(mdout[1])
    );

    // BRAM models: lane 3 = byte offset 0; synchronous read of latency 1 and 3.
    logic [31:0] bram[2][32768];
    logic [31:0] p3[2];
    int          wr_cnt[2] = '{0, 0};
    logic        pre_done = 1'b0;

    always @(posedge clk) begin
        if (!pre_done) begin
            bram[0][15'h040] <= 32'h801234F5;
            bram[1][15'h0C0] <= 32'h11223344;
            pre_done <= 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            if (mwe[d] != 4'b0000) begin
                for (int l = 0; l < 4; l++)
                    if (mwe[d][l]) bram[d][maddr[d]][8*l +: 8] <= mdin[d][8*l +: 8];
                wr_cnt[d] <= wr_cnt[d] + 1;
            end
        end
        mdout[0] <= bram[0][maddr[0]];
        p3[0]    <= bram[1][maddr[1]];
        p3[1]    <= p3[0];
        mdout[1] <= p3[1];
    end

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    int total = 0;
    int bad = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: architectural byte memory plus per-request expectations.
    logic [7:0]  bmem[int unsigned];
    int          lat_of[2] = '{1, 3};
    int          acc[2] = '{-1, -1};
    int          busy_to[2] = '{-1, -1};
    int          resp_at[2] = '{-1, -1};
    int          we_at[2] = '{-1, -1};
    int          addr_lo[2] = '{-1, -1};
    int          addr_hi[2] = '{-1, -1};
    logic [3:0]  exp_we[2];
    logic [31:0] exp_din[2], exp_rd[2], exp_addr[2];
    logic        exp_f[2];

    function automatic int unsigned bkey(input int d, input logic [31:0] a);
        return (int'(d) << 20) | (a & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    task automatic model_accept(input int d);
        int sz, lat, lane;
        logic legal, flt;
        logic [31:0] a, v, b;
        a = ra[d];
        case (rf[d])
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            default:    sz = 4;
        endcase
        legal = rs[d] ? (rf[d] <= 3'd2) : (rf[d] <= 3'd2 || rf[d] == 3'd4 || rf[d] == 3'd5);
        flt = !legal || ((a % sz) != 0);
        lat = flt ? 1 : (rs[d] ? 2 : 2 + lat_of[d]);
        acc[d] = cyc;
        busy_to[d] = cyc + lat;
        resp_at[d] = cyc + lat;
        exp_f[d] = flt;
        exp_rd[d] = '0;
        we_at[d] = -1;
        addr_lo[d] = -1;
        addr_hi[d] = -1;
        if (!flt) begin
            exp_addr[d] = (a >> 2) & 32'h7FFF;
            addr_lo[d] = cyc + 1;
            addr_hi[d] = rs[d] ? cyc + 1 : cyc + 1 + lat_of[d];
            if (rs[d]) begin
                we_at[d] = cyc + 1;
                exp_we[d] = '0;
                exp_din[d] = '0;
                for (int i = 0; i < sz; i++) begin
                    b = a + i;
                    lane = 3 - int'(b % 4);
                    exp_we[d][lane] = 1'b1;
                    exp_din[d][8*lane +: 8] = rw[d][8*i +: 8];
                    bmem[bkey(d, b)] = rw[d][8*i +: 8];
                end
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) begin
                    b = a + i;
                    if (bmem.exists(bkey(d, b))) v[8*i +: 8] = bmem[bkey(d, b)];
                end
                if (rf[d] == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
                if (rf[d] == 3'd1 && v[15]) v = v | 32'hFFFF0000;
                exp_rd[d] = v;
            end
        end
    endtask

    task automatic monitor();
        bmem[bkey(0, 32'h100)] = 8'h80;
        bmem[bkey(0, 32'h101)] = 8'h12;
        bmem[bkey(0, 32'h102)] = 8'h34;
        bmem[bkey(0, 32'h103)] = 8'hF5;
        bmem[bkey(1, 32'h300)] = 8'h11;
        bmem[bkey(1, 32'h301)] = 8'h22;
        bmem[bkey(1, 32'h302)] = 8'h33;
        bmem[bkey(1, 32'h303)] = 8'h44;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int d = 0; d < 2; d++) begin
                    if (rst_q) begin
                        acc[d] = -1; busy_to[d] = -1; resp_at[d] = -1;
                        we_at[d] = -1; addr_lo[d] = -1; addr_hi[d] = -1;
                        chk($sformatf("d%0d_rst_resp_valid", d), resp_v[d], 0);
                        chk($sformatf("d%0d_rst_mem_we", d), mwe[d], 0);
                    end else begin
                        chk($sformatf("d%0d_resp_valid", d), resp_v[d], cyc == resp_at[d]);
                        if (cyc == resp_at[d] && resp_v[d]) begin
                            chk($sformatf("d%0d_resp_rdata", d), resp_d[d], exp_rd[d]);
                            chk($sformatf("d%0d_resp_fault", d), resp_f[d], exp_f[d]);
                        end
                        chk($sformatf("d%0d_mem_we", d), mwe[d], (cyc == we_at[d]) ? exp_we[d] : 4'b0000);
                        if (cyc == we_at[d])
                            chk($sformatf("d%0d_mem_din", d), mdin[d] & lane_mask(exp_we[d]), exp_din[d]);
                        if (cyc >= addr_lo[d] && cyc <= addr_hi[d])
                            chk($sformatf("d%0d_mem_addr", d), maddr[d], exp_addr[d]);
                    end
                    chk($sformatf("d%0d_req_ready", d), rdy[d],
                        !rst && !(cyc > acc[d] && cyc <= busy_to[d]));
                    if (rv[d] && rdy[d] && !rst) model_accept(d);
                end
            end
        end
    endtask

    task automatic drive(input int d, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        rv[d] = 1'b1; rs[d] = st; rf[d] = f3; ra[d] = a; rw[d] = wd;
    endtask

    task automatic wait_accept(input int d, output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy[d] && rv[d]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("accept_timeout", rdy[d], 1);
    endtask

    task automatic wait_resp(input int d, output int t, output logic [31:0] rd, output logic f,
                             output logic [3:0] we1, output logic [31:0] din1, output logic [31:0] ma1);
        t = -1; rd = '0; f = 1'b0; we1 = '0; din1 = '0; ma1 = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                we1 = mwe[d]; din1 = mdin[d]; ma1 = {17'h0, maddr[d]};
            end
            if (resp_v[d]) begin
                t = cyc; rd = resp_d[d]; f = resp_f[d];
                break;
            end
        end
        if (t < 0) chk("resp_timeout", resp_v[d], 1);
    endtask

    task automatic xact(input string nm, input int d, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] lit_rd, input logic lit_f, input int lit_lat,
                        input logic [3:0] lit_we, input logic [31:0] lit_din, input logic [31:0] lit_ma);
        int t0, t1;
        logic [31:0] rd, din1, ma1, m;
        logic f;
        logic [3:0] we1;
        @(posedge clk); #1;
        drive(d, st, f3, a, wd);
        wait_accept(d, t0);
        @(posedge clk); #1;
        rv[d] = 1'b0;
        wait_resp(d, t1, rd, f, we1, din1, ma1);
        m = lane_mask(lit_we);
        chk({nm, "_latency"}, t1 - t0, lit_lat);
        chk({nm, "_rdata"}, rd, lit_rd);
        chk({nm, "_fault"}, f, lit_f);
        chk({nm, "_we"}, we1, lit_we);
        chk({nm, "_din"}, din1 & m, lit_din & m);
        if (!lit_f) chk({nm, "_addr"}, ma1, lit_ma);
    endtask

    int t0, t1, t2, t3, snap;
    logic [31:0] rd, din1, ma1;
    logic f;
    logic [3:0] we1;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; rs[d] = 1'b0; rf[d] = '0; ra[d] = '0; rw[d] = '0;
        end
        fork
            monitor();
        join_none
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", rdy[0], 0);
        chk("reset_mem_addr", maddr[0], 0);
        chk("reset_mem_din", mdin[0], 0);
        chk("reset_resp_rdata", resp_d[0], 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_cycle_ready", rdy[0], 1);

        // Extension, latency 1
        xact("lb",   0, 0, F3_B,  32'h100,   0, 32'hFFFFFF80, 0, 3, 4'b0000, 0, 32'h40);
        xact("lbu",  0, 0, F3_BU, 32'h101,   0, 32'h00000012, 0, 3, 4'b0000, 0, 32'h40);
        xact("lh",   0, 0, F3_H,  32'h102,   0, 32'hFFFFF534, 0, 3, 4'b0000, 0, 32'h40);
        xact("lhu",  0, 0, F3_HU, 32'h102,   0, 32'h0000F534, 0, 3, 4'b0000, 0, 32'h40);
        xact("lw",   0, 0, F3_W,  32'h100,   0, 32'hF5341280, 0, 3, 4'b0000, 0, 32'h40);
        xact("wrap", 0, 0, F3_BU, 32'h20101, 0, 32'h00000012, 0, 3, 4'b0000, 0, 32'h40);

        // Stores and read-back of the merged word
        xact("sb", 0, 1, F3_B, 32'h103, 32'h000000AB, 0, 0, 2, 4'b0001, 32'h000000AB, 32'h40);
        xact("sh", 0, 1, F3_H, 32'h102, 32'h00001234, 0, 0, 2, 4'b0011, 32'h00003412, 32'h40);
        xact("sw", 0, 1, F3_W, 32'h104, 32'h11223344, 0, 0, 2, 4'b1111, 32'h44332211, 32'h41);
        xact("lw_merged", 0, 0, F3_W, 32'h100, 0, 32'h12341280, 0, 3, 4'b0000, 0, 32'h40);

        // Faults
        xact("lw_mis",  0, 0, F3_W,   32'h102, 0,          0, 1, 1, 4'b0000, 0, 0);
        xact("sh_mis",  0, 1, F3_H,   32'h101, 32'h5555,   0, 1, 1, 4'b0000, 0, 0);
        xact("ld_f3_3", 0, 0, 3'b011, 32'h100, 0,          0, 1, 1, 4'b0000, 0, 0);
        xact("st_f3_4", 0, 1, F3_BU,  32'h100, 32'hFF,     0, 1, 1, 4'b0000, 0, 0);

        // Latency 3 with a request held through the busy window
        @(posedge clk); #1;
        drive(1, 0, F3_W, 32'h300, 0);
        wait_accept(1, t0);
        @(posedge clk); #1;
        drive(1, 0, F3_BU, 32'h301, 0);
        wait_resp(1, t1, rd, f, we1, din1, ma1);
        chk("l3_lw_latency", t1 - t0, 5);
        chk("l3_lw_rdata", rd, 32'h44332211);
        wait_accept(1, t2);
        chk("l3_held_accept", t2 - t0, 6);
        @(posedge clk); #1;
        rv[1] = 1'b0;
        wait_resp(1, t3, rd, f, we1, din1, ma1);
        chk("l3_lbu_latency", t3 - t2, 5);
        chk("l3_lbu_rdata", rd, 32'h00000022);

        // Reset in the write cycle of a store
        @(posedge clk); #1;
        drive(0, 1, F3_W, 32'h400, 32'hCAFEF00D);
        wait_accept(0, t0);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_low", rdy[0], 0);
        @(posedge clk); #1;
        snap = wr_cnt[0];
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", rdy[0], 1);
        chk("post_rst_we", mwe[0], 0);
        chk("post_rst_resp", resp_v[0], 0);
        repeat (4) @(negedge clk);
        chk("post_rst_no_write", wr_cnt[0], snap);

        // Back-to-back store then load
        xact("sw_b2b", 0, 1, F3_W, 32'h200, 32'hDEADBEEF, 0, 0, 2, 4'b1111, 32'hEFBEADDE, 32'h80);
        xact("lw_b2b", 0, 0, F3_W, 32'h200, 0, 32'hDEADBEEF, 0, 3, 4'b0000, 0, 32'h80);

        repeat (3) @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
